// File: rtl/ram_arbiter_pkg.sv
// ram_arb_pkg: shared types and defaults for the RAM arbiter slice.
//   - ADDR_W_DEF / DATA_W_DEF / LOCK_MAX_DEF : default geometry and lock limit
//   - src_t   : which requester issued an access
//   - stage_t : one pipeline slot travelling towards the read-data return
package ram_arb_pkg;

    localparam int ADDR_W_DEF   = 12;
    localparam int DATA_W_DEF   = 16;
    localparam int LOCK_MAX_DEF = 16;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

    typedef struct packed {
        logic valid;
        src_t src;
        logic rd;
    } stage_t;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant logic with an optional B burst lock.
// Ports:
//   clk, rst_n       : clock (rising edge), async active-low reset
//   i_a_req, i_b_req : requests from port A and port B
//   i_b_lock         : B asks to keep the grant on its next beat
//   o_a_gnt, o_b_gnt : combinational one-hot (or zero) grant
// Handshake: a transfer happens on a rising edge where req && gnt; the
// requester holds req and its fields until it sees gnt.
module rr_arb2
    import ram_arb_pkg::*;
#(
    parameter int LOCK_MAX = LOCK_MAX_DEF
)(
    input  logic clk,
    input  logic rst_n,
    input  logic i_a_req,
    input  logic i_b_req,
    input  logic i_b_lock,
    output logic o_a_gnt,
    output logic o_b_gnt
);

    localparam int               CNT_W      = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

    src_t             r_last_served;
    logic             r_lock_act;
    logic [CNT_W-1:0] r_lock_cnt;

    logic w_a_gnt;
    logic w_b_gnt;
    logic w_a_xfer;
    logic w_b_xfer;
    logic w_lock_clr;
    logic w_lock_ok;

    // The lock only wins a contested cycle while it has not yet starved A
    // for LOCK_MAX locked beats.
    assign w_lock_ok = r_lock_act && (r_lock_cnt < LOCK_MAX_C);

    always_comb begin
        w_a_gnt = 1'b0;
        w_b_gnt = 1'b0;
        if (i_a_req && i_b_req) begin
            if (w_lock_ok) begin
                w_b_gnt = 1'b1;
            end else if (r_last_served == SRC_A) begin
                w_b_gnt = 1'b1;
            end else begin
                w_a_gnt = 1'b1;
            end
        end else if (i_a_req) begin
            w_a_gnt = 1'b1;
        end else if (i_b_req) begin
            w_b_gnt = 1'b1;
        end
    end

    assign w_a_xfer   = i_a_req & w_a_gnt;
    assign w_b_xfer   = i_b_req & w_b_gnt;
    // Lock drops when B goes idle or finishes a beat without asking to keep it.
    assign w_lock_clr = ~i_b_req | (w_b_xfer & ~i_b_lock);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_served <= SRC_B;
            r_lock_act    <= 1'b0;
            r_lock_cnt    <= '0;
        end else begin
            if (w_a_xfer) begin
                r_last_served <= SRC_A;
            end else if (w_b_xfer) begin
                r_last_served <= SRC_B;
            end

            if (w_lock_clr) begin
                r_lock_act <= 1'b0;
            end else if (w_b_xfer) begin
                r_lock_act <= 1'b1;
            end

            // Only beats taken under an already-active lock while A waits
            // count towards the starvation limit.
            if (w_a_xfer || w_lock_clr) begin
                r_lock_cnt <= '0;
            end else if (w_b_xfer && i_a_req && r_lock_act && (r_lock_cnt < LOCK_MAX_C)) begin
                r_lock_cnt <= r_lock_cnt + CNT_W'(1);
            end
        end
    end

    assign o_a_gnt = w_a_gnt;
    assign o_b_gnt = w_b_gnt;

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port block RAM between port A (CPU) and
// port B (loader/debug), one access per cycle, fully pipelined.
// Ports:
//   clk, rst_n                            : clock, async active-low reset
//   a_req/a_we/a_addr/a_wdata -> a_gnt    : A command and combinational grant
//   a_rvalid/a_rdata                      : A read return
//   b_req/b_we/b_addr/b_wdata/b_lock -> b_gnt, b_rvalid/b_rdata : same for B
//   ram_addr/ram_data/ram_wren, ram_q     : registered RAM pins, RAM read data
//   busy                                  : request pending or access in flight
// Read timeline: accepted at edge T, on the RAM pins after T, captured by the
// RAM at T+1, data and rvalid presented after T+2 for one cycle.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic              b_lock,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);

    logic w_a_gnt;
    logic w_b_gnt;
    logic w_a_xfer;
    logic w_b_xfer;

    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_data;
    logic              r_ram_wren;
    stage_t            r_s1;
    stage_t            r_s2;
    logic              r_a_rvalid;
    logic              r_b_rvalid;

    rr_arb2 #(
        .LOCK_MAX (LOCK_MAX)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_a_req  (a_req),
        .i_b_req  (b_req),
        .i_b_lock (b_lock),
        .o_a_gnt  (w_a_gnt),
        .o_b_gnt  (w_b_gnt)
    );

    assign w_a_xfer = a_req & w_a_gnt;
    assign w_b_xfer = b_req & w_b_gnt;

    // Async reset clears ram_wren, so a write still sitting on the pins is
    // never clocked into the RAM, and in-flight reads never return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_addr <= '0;
            r_ram_data <= '0;
            r_ram_wren <= 1'b0;
            r_s1       <= '0;
            r_s2       <= '0;
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
        end else begin
            if (w_b_xfer) begin
                r_ram_addr <= b_addr;
                r_ram_data <= b_wdata;
                r_ram_wren <= b_we;
                r_s1       <= '{valid: 1'b1, src: SRC_B, rd: ~b_we};
            end else if (w_a_xfer) begin
                r_ram_addr <= a_addr;
                r_ram_data <= a_wdata;
                r_ram_wren <= a_we;
                r_s1       <= '{valid: 1'b1, src: SRC_A, rd: ~a_we};
            end else begin
                r_ram_wren <= 1'b0;
                r_s1.valid <= 1'b0;
            end

            r_s2       <= r_s1;
            r_a_rvalid <= r_s2.valid & r_s2.rd & (r_s2.src == SRC_A);
            r_b_rvalid <= r_s2.valid & r_s2.rd & (r_s2.src == SRC_B);
        end
    end

    assign a_gnt    = w_a_gnt;
    assign b_gnt    = w_b_gnt;
    assign ram_addr = r_ram_addr;
    assign ram_data = r_ram_data;
    assign ram_wren = r_ram_wren;
    assign a_rvalid = r_a_rvalid;
    assign b_rvalid = r_b_rvalid;
    // Both ports see the RAM output; rvalid says whose it is.
    assign a_rdata  = ram_q;
    assign b_rdata  = ram_q;
    assign busy     = a_req | b_req | r_s1.valid | r_s2.valid;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_req, a_we, a_gnt, a_rvalid;
    logic [11:0] a_addr;
    logic [15:0] a_wdata, a_rdata;
    logic        b_req, b_we, b_lock, b_gnt, b_rvalid;
    logic [11:0] b_addr;
    logic [15:0] b_wdata, b_rdata;
    logic [11:0] ram_addr;
    logic [15:0] ram_data, ram_q;
    logic        ram_wren, busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [15:0] exp_a_q[$];
    logic [15:0] exp_b_q[$];
    int          due_a_q[$];
    int          due_b_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_gnt    (a_gnt),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_lock   (b_lock),
        .b_gnt    (b_gnt),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_wren (ram_wren),
        .ram_q    (ram_q),
        .busy     (busy)
    );

    // ---------------- block RAM model ----------------
    // Captures the pins at an edge, presents data one cycle later.
    // Unwritten words read as 0x5000 | addr.
    logic [15:0] mem [0:4095];
    bit          wr_valid [0:4095];
    logic [11:0] r_ra;

    always @(posedge clk) begin
        if (ram_wren) begin
            mem[ram_addr]      <= ram_data;
            wr_valid[ram_addr] <= 1'b1;
        end
        r_ra  <= ram_addr;
        ram_q <= wr_valid[r_ra] ? mem[r_ra] : (16'h5000 | {4'h0, r_ra});
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents read data.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_rvalid) begin
                if (exp_a_q.size() == 0) begin
                    check("a_rvalid_unexpected", {31'd0, a_rvalid}, 32'd0);
                end else begin
                    check("a_rdata", {16'd0, a_rdata}, {16'd0, exp_a_q.pop_front()});
                    check("a_rvalid_cycle", cyc, due_a_q.pop_front());
                end
            end
            if (b_rvalid) begin
                if (exp_b_q.size() == 0) begin
                    check("b_rvalid_unexpected", {31'd0, b_rvalid}, 32'd0);
                end else begin
                    check("b_rdata", {16'd0, b_rdata}, {16'd0, exp_b_q.pop_front()});
                    check("b_rvalid_cycle", cyc, due_b_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver ----------------
    // One cycle: drive both ports, check the grants at the falling edge,
    // queue expected read data for the expected winner, step past the edge.
    task automatic do_cycle(
        input string tag,
        input logic ar, input logic aw, input logic [11:0] aa, input logic [15:0] ad,
        input logic br, input logic bw, input logic [11:0] ba, input logic [15:0] bd,
        input logic bl,
        input logic exp_ag, input logic exp_bg,
        input logic [15:0] a_exp, input logic [15:0] b_exp);
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd; b_lock = bl;
        @(negedge clk);
        check({tag, "_a_gnt"}, {31'd0, a_gnt}, {31'd0, exp_ag});
        check({tag, "_b_gnt"}, {31'd0, b_gnt}, {31'd0, exp_bg});
        // Read data shows up at the third falling edge after this one.
        if (exp_ag && ar && !aw) begin
            exp_a_q.push_back(a_exp);
            due_a_q.push_back(cyc + 3);
        end
        if (exp_bg && br && !bw) begin
            exp_b_q.push_back(b_exp);
            due_b_q.push_back(cyc + 3);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0; b_lock = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 12'h000; a_wdata = 16'h0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 12'h000; b_wdata = 16'h0; b_lock = 1'b0;

        // Reset held with both ports requesting.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ram_wren", {31'd0, ram_wren}, 32'd0);
        check("rst_ram_addr", {20'd0, ram_addr}, 32'd0);
        check("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
        check("rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First tie after reset goes to A, then B alone.
        do_cycle("first", 1, 0, 12'h001, 16'h0, 1, 0, 12'h002, 16'h0, 0, 1, 0, 16'h5001, 16'h0);
        do_cycle("first_b", 0, 0, 12'h000, 16'h0, 1, 0, 12'h002, 16'h0, 0, 0, 1, 16'h0, 16'h5002);

        // Continuous reads from both: strict alternation A,B,A,B,A,B.
        begin
            logic [11:0] ia, ib;
            ia = 12'h000; ib = 12'h000;
            for (int k = 0; k < 6; k++) begin
                do_cycle("alt", 1, 0, 12'h010 + ia, 16'h0, 1, 0, 12'h020 + ib, 16'h0, 0,
                         (k % 2) == 0, (k % 2) == 1,
                         16'h5010 + {4'h0, ia}, 16'h5020 + {4'h0, ib});
                if ((k % 2) == 0) ia = ia + 12'h1;
                else              ib = ib + 12'h1;
            end
        end

        // A write then A read of the same word on the next cycle.
        do_cycle("a_wr", 1, 1, 12'h005, 16'hA0FA, 0, 0, 12'h000, 16'h0, 0, 1, 0, 16'h0, 16'h0);
        a_req = 1'b1;
        @(negedge clk);
        check("a_wr_ram_wren", {31'd0, ram_wren}, 32'd1);
        check("a_wr_ram_addr", {20'd0, ram_addr}, 32'h005);
        check("a_wr_ram_data", {16'd0, ram_data}, 32'hA0FA);
        @(posedge clk);
        #1;
        do_cycle("a_rd", 1, 0, 12'h005, 16'h0, 0, 0, 12'h000, 16'h0, 0, 1, 0, 16'hA0FA, 16'h0);
        idle(4);
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;

        // B burst: 4 locked beats + 1 unlocked beat while A waits, then A.
        for (int k = 0; k < 5; k++) begin
            do_cycle("burst", 1, 0, 12'h040, 16'h0, 1, 0, 12'h030 + 12'(k), 16'h0, k < 4,
                     0, 1, 16'h5040, 16'h5030 + 16'(k));
        end
        do_cycle("burst_a", 1, 0, 12'h040, 16'h0, 0, 0, 12'h000, 16'h0, 0, 1, 0, 16'h5040, 16'h0);
        idle(2);

        // Lock held continuously: 1 round-robin B beat + 16 locked beats,
        // then A gets exactly one grant, then B again.
        for (int i = 0; i < 19; i++) begin
            do_cycle("lock", i <= 17, 0, 12'h050, 16'h0, 1, 1, 12'h100 + 12'(i), 16'(i), 1,
                     i == 17, i != 17, 16'h5050, 16'h0);
        end
        idle(2);

        // B write at T, A read of the same word at T+1.
        do_cycle("order_b", 0, 0, 12'h000, 16'h0, 1, 1, 12'h0FF, 16'h1234, 0, 0, 1, 16'h0, 16'h0);
        do_cycle("order_a", 1, 0, 12'h0FF, 16'h0, 0, 0, 12'h000, 16'h0, 0, 1, 0, 16'h1234, 16'h0);
        // Word written during the lock run.
        do_cycle("lock_wr", 0, 0, 12'h000, 16'h0, 1, 0, 12'h105, 16'h0, 0, 0, 1, 16'h0, 16'h0005);
        idle(5);

        // Reset mid-operation: read in flight and a write on the pins.
        do_cycle("mid_rd", 1, 0, 12'h060, 16'h0, 0, 0, 12'h000, 16'h0, 0, 1, 0, 16'h5060, 16'h0);
        do_cycle("mid_wr", 1, 1, 12'h061, 16'hBEEF, 0, 0, 12'h000, 16'h0, 0, 1, 0, 16'h0, 16'h0);
        a_req = 1'b0;
        rst_n = 1'b0;
        exp_a_q.delete();
        due_a_q.delete();
        exp_b_q.delete();
        due_b_q.delete();
        #1;
        check("mid_ram_wren", {31'd0, ram_wren}, 32'd0);
        check("mid_s1_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);
        // Cancelled write must leave the old contents.
        do_cycle("post_rd1", 1, 0, 12'h061, 16'h0, 0, 0, 12'h000, 16'h0, 0, 1, 0, 16'h5061, 16'h0);
        do_cycle("post_rd2", 1, 0, 12'h060, 16'h0, 0, 0, 12'h000, 16'h0, 0, 1, 0, 16'h5060, 16'h0);
        idle(1);

        // Drain: every queued read must have come back.
        for (int w = 0; w < 20; w++) begin
            if (exp_a_q.size() == 0 && exp_b_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        check("exp_a_q_drained", exp_a_q.size(), 32'd0);
        check("exp_b_q_drained", exp_b_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
